// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared state types, framing constants and width helper for the word SPART
package spart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BITS_PER_FRAME = 10;

  // Bits needed to hold a counter running 0 .. value-1 (at least 1).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/spart_rx_byte.sv
// rtl/spart_rx_byte.sv - synchronised 8N1 byte receiver with glitch reject and mid-bit sampling
module spart_rx_byte
  import spart_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o,
  output logic       idle_o
);

  localparam int CNT_W = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [2:0]       DATA_LAST = 3'(BITS_PER_FRAME - 3);

  logic             rxd_meta_q;
  logic             rxd_sync_q;
  logic             rxd_prev_q;
  rx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             stop_sample;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; line idles high.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // Receive FSM: start edge, half-bit glitch check, then one sample per bit centre.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (rxd_prev_q && !rxd_sync_q) begin
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            bit_q <= '0;
            state_q <= rxd_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rxd_sync_q, shift_q[7:1]};
            if (bit_q == DATA_LAST) begin
              state_q <= RX_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign stop_sample  = (state_q == RX_STOP) && (cnt_q == BIT_LAST);
  assign byte_valid_o = stop_sample && rxd_sync_q;
  assign frame_err_o  = stop_sample && !rxd_sync_q;
  assign byte_o       = shift_q;
  assign idle_o       = (state_q == RX_IDLE);

endmodule

// File: rtl/spart_word.sv
// rtl/spart_word.sv - 32-bit word SPART: 4-byte little-endian 8N1 transmit with one pending slot, word receive
module spart_word
  import spart_pkg::*;
#(
  parameter int CLK_DIV      = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [31:0] tx_data,
  output logic        tx_busy,
  output logic        tx_overflow,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  output logic        rx_frame_err
);

  localparam int CNT_W = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]       DATA_LAST = 3'(BITS_PER_FRAME - 3);
  localparam logic [1:0]       BYTE_LAST = 2'(BYTES_PER_WORD - 1);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLK_DIV;
  localparam int TO_W      = clog2(TO_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  // Transmit state
  tx_state_t        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [1:0]       tx_byte_q;
  logic [31:0]      tx_shift_q;
  logic             pend_vld_q;
  logic [31:0]      pend_data_q;
  logic             txd_q;
  logic             tx_busy_q;
  logic             tx_ovf_q;

  // Receive word assembly state
  logic        rxb_valid;
  logic [7:0]  rxb_byte;
  logic        rxb_frame_err;
  logic        rxb_idle;
  logic [1:0]  rx_byte_cnt_q;
  logic [23:0] rx_buf_q;
  logic [31:0] rx_data_q;
  logic        rx_valid_q;
  logic        rx_ferr_q;
  logic [TO_W-1:0] to_cnt_q;

  // Transmit FSM: start, 8 data bits LSB first, stop; four frames per word back to back,
  // followed directly by the pending word if one was queued.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_byte_q   <= '0;
      tx_shift_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      txd_q       <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_ovf_q    <= 1'b0;
    end else begin
      tx_ovf_q <= 1'b0;
      // A request while busy goes to the single pending slot, or is dropped if it is taken.
      if (tx_start && tx_busy_q) begin
        if (!pend_vld_q) begin
          pend_vld_q  <= 1'b1;
          pend_data_q <= tx_data;
        end else begin
          tx_ovf_q <= 1'b1;
        end
      end
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_start) begin
            tx_shift_q <= tx_data;
            tx_cnt_q   <= '0;
            tx_byte_q  <= '0;
            tx_state_q <= TX_START;
            txd_q      <= 1'b0;
            tx_busy_q  <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
            txd_q      <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= {1'b0, tx_shift_q[31:1]};
            if (tx_bit_q == DATA_LAST) begin
              tx_state_q <= TX_STOP;
              txd_q      <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              txd_q    <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_byte_q == BYTE_LAST) begin
              tx_byte_q <= '0;
              if (pend_vld_q) begin
                tx_shift_q <= pend_data_q;
                pend_vld_q <= 1'b0;
                tx_state_q <= TX_START;
                txd_q      <= 1'b0;
              end else if (tx_start) begin
                // Request landing on the final cycle: chained straight in instead of via the slot.
                tx_shift_q <= tx_data;
                pend_vld_q <= 1'b0;
                tx_state_q <= TX_START;
                txd_q      <= 1'b0;
              end else begin
                tx_state_q <= TX_IDLE;
                txd_q      <= 1'b1;
                tx_busy_q  <= 1'b0;
              end
            end else begin
              tx_byte_q  <= tx_byte_q + 1'b1;
              tx_state_q <= TX_START;
              txd_q      <= 1'b0;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  spart_rx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_rx_byte (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .rxd_i        (uart_rxd),
    .byte_valid_o (rxb_valid),
    .byte_o       (rxb_byte),
    .frame_err_o  (rxb_frame_err),
    .idle_o       (rxb_idle)
  );

  // Word assembly: little-endian byte placement, frame-error and inter-byte timeout discard.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rx_byte_cnt_q <= '0;
      rx_buf_q      <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_ferr_q     <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      if (rxb_frame_err) begin
        rx_ferr_q     <= 1'b1;
        rx_byte_cnt_q <= '0;
        to_cnt_q      <= '0;
      end else if (rxb_valid) begin
        to_cnt_q <= '0;
        if (rx_byte_cnt_q == BYTE_LAST) begin
          rx_data_q     <= {rxb_byte, rx_buf_q};
          rx_valid_q    <= 1'b1;
          rx_byte_cnt_q <= '0;
        end else begin
          case (rx_byte_cnt_q)
            2'd0:    rx_buf_q[7:0]   <= rxb_byte;
            2'd1:    rx_buf_q[15:8]  <= rxb_byte;
            default: rx_buf_q[23:16] <= rxb_byte;
          endcase
          rx_byte_cnt_q <= rx_byte_cnt_q + 1'b1;
        end
      end else if (!rxb_idle || rx_byte_cnt_q == 2'd0) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q == TO_LAST) begin
        to_cnt_q      <= '0;
        rx_byte_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  assign uart_txd     = txd_q;
  assign tx_busy      = tx_busy_q;
  assign tx_overflow  = tx_ovf_q;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign rx_frame_err = rx_ferr_q;

endmodule

// File: tb/tb_spart_word.sv
// tb/tb_spart_word.sv - randomized self-checking bench for spart_word with a line-level reference model
module tb_spart_word;

  localparam int DIV = 8;
  localparam int TO  = 20;
  localparam int WORD_CYC = 40 * DIV;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic [31:0] tx_data = '0;
  logic        drv_rxd = 1'b1;
  logic        loop_en = 1'b0;
  logic        rxd_line;
  logic        tx_busy, tx_overflow, uart_txd, rx_valid, rx_frame_err;
  logic [31:0] rx_data;

  assign rxd_line = loop_en ? uart_txd : drv_rxd;

  spart_word #(.CLK_DIV(DIV), .TIMEOUT_BITS(TO)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_overflow  (tx_overflow),
    .uart_txd     (uart_txd),
    .uart_rxd     (rxd_line),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rx_valid_cnt = 0, frame_err_cnt = 0, ovf_cnt = 0, exp_ovf = 0;
  int busy_run = 0;
  int busy_lens[$];
  logic [31:0] rx_words[$];
  logic [8:0]  tx_bytes[$];
  logic [31:0] exp_words[$];
  logic [8:0]  exp_bytes[$];
  int          word_ends[$];
  logic [31:0] last_rx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulse counters, received words and busy run lengths, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (rx_valid === 1'b1) begin
      rx_valid_cnt++;
      rx_words.push_back(rx_data);
    end
    if (rx_frame_err === 1'b1) frame_err_cnt++;
    if (tx_overflow === 1'b1) ovf_cnt++;
    if (tx_busy === 1'b1) busy_run++;
    else if (busy_run > 0) begin
      busy_lens.push_back(busy_run);
      busy_run = 0;
    end
  end

  // Independent UART decoder on the transmit line: {stop, data} per frame.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge sys_clk);
      if (rst_n === 1'b1 && uart_txd === 1'b0) begin
        repeat (DIV / 2) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge sys_clk);
          b[i] = uart_txd;
        end
        repeat (DIV) @(negedge sys_clk);
        tx_bytes.push_back({uart_txd, b});
      end
    end
  end

  // Reference model: a word occupies the line for 40 bit times; at most one active plus one waiting.
  task automatic send_word(input logic [31:0] w);
    int j;
    int st;
    @(negedge sys_clk);
    j = cyc + 1;
    while (word_ends.size() > 0 && word_ends[0] < j) void'(word_ends.pop_front());
    if (word_ends.size() < 2) begin
      st = (word_ends.size() == 0) ? j : word_ends[$];
      word_ends.push_back(st + WORD_CYC);
      for (int k = 0; k < 4; k++) exp_bytes.push_back({1'b1, w[8*k +: 8]});
      if (loop_en) exp_words.push_back(w);
    end else begin
      exp_ovf++;
    end
    tx_start = 1'b1;
    tx_data  = w;
    @(negedge sys_clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_tx_done();
    for (int i = 0; i < 3000 && tx_busy === 1'b1; i++) @(negedge sys_clk);
    check("tx_done", {31'd0, tx_busy}, 32'd0);
    repeat (2 * DIV) @(negedge sys_clk);
  endtask

  task automatic compare_tx();
    check("tx_nbytes", 32'(tx_bytes.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < tx_bytes.size(); i++)
      check("tx_byte", {23'd0, tx_bytes[i]}, {23'd0, exp_bytes[i]});
    tx_bytes.delete();
    exp_bytes.delete();
  endtask

  task automatic compare_rx();
    check("rx_nwords", 32'(rx_words.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < rx_words.size(); i++)
      check("rx_word", rx_words[i], exp_words[i]);
    rx_words.delete();
    exp_words.delete();
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic stop);
    drv_rxd = 1'b0;
    repeat (DIV) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      drv_rxd = b[i];
      repeat (DIV) @(negedge sys_clk);
    end
    drv_rxd = stop;
    repeat (DIV) @(negedge sys_clk);
    drv_rxd = 1'b1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int v0, f0;
    logic [31:0] w;
    repeat (4) @(negedge sys_clk);
    rst_n = 1'b1;

    // Reset state over an idle stretch
    repeat (100) @(negedge sys_clk);
    check("rst_txd", {31'd0, uart_txd}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_rx_data", rx_data, 32'd0);
    check("rst_pulses", 32'(rx_valid_cnt + frame_err_cnt + ovf_cnt), 32'd0);

    // Single word on the line, latency and busy length
    busy_lens.delete();
    send_word(32'hA5C3_0F01);
    check("tx_first_start", {31'd0, uart_txd}, 32'd0);
    check("tx_first_busy", {31'd0, tx_busy}, 32'd1);
    wait_tx_done();
    check("busy_len_1", 32'(busy_lens.size() > 0 ? busy_lens[0] : 0), 32'(WORD_CYC));
    compare_tx();

    // Loopback: two chained words plus a dropped third
    loop_en = 1'b1;
    busy_lens.delete();
    repeat (DIV) @(negedge sys_clk);
    send_word(32'hDEAD_BEEF);
    repeat (20) @(negedge sys_clk);
    send_word(32'h1234_5678);
    repeat (20) @(negedge sys_clk);
    send_word($urandom);
    wait_tx_done();
    check("busy_len_2", 32'(busy_lens.size() > 0 ? busy_lens[0] : 0), 32'(2 * WORD_CYC));
    check("overflow", 32'(ovf_cnt), 32'(exp_ovf));
    compare_tx();
    compare_rx();

    // Randomized loopback traffic with random spacing
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 400)) @(negedge sys_clk);
      w = $urandom;
      send_word(w);
    end
    wait_tx_done();
    check("overflow_rand", 32'(ovf_cnt), 32'(exp_ovf));
    if (exp_words.size() > 0) last_rx = exp_words[$];
    compare_tx();
    compare_rx();
    loop_en = 1'b0;
    repeat (2 * DIV) @(negedge sys_clk);

    // Bad stop bit, then a clean word
    v0 = rx_valid_cnt;
    f0 = frame_err_cnt;
    drive_byte(8'h55, 1'b0);
    repeat (2 * DIV) @(negedge sys_clk);
    check("ferr_pulse", 32'(frame_err_cnt - f0), 32'd1);
    check("ferr_no_valid", 32'(rx_valid_cnt - v0), 32'd0);
    check("ferr_data_kept", rx_data, last_rx);
    w = 32'h0000_0001;
    for (int k = 0; k < 4; k++) drive_byte(w[8*k +: 8], 1'b1);
    repeat (2 * DIV) @(negedge sys_clk);
    check("clean_after_ferr", rx_data, 32'h0000_0001);
    check("clean_valid", 32'(rx_valid_cnt - v0), 32'd1);

    // Glitch, then two bytes abandoned by timeout, then a full word
    v0 = rx_valid_cnt;
    f0 = frame_err_cnt;
    drv_rxd = 1'b0;
    repeat (3) @(negedge sys_clk);
    drv_rxd = 1'b1;
    repeat (3 * DIV) @(negedge sys_clk);
    check("glitch_quiet", 32'(rx_valid_cnt - v0 + frame_err_cnt - f0), 32'd0);
    drive_byte($urandom_range(0, 255), 1'b1);
    drive_byte($urandom_range(0, 255), 1'b1);
    repeat (TO * DIV) @(negedge sys_clk);
    drive_byte(8'h11, 1'b1);
    drive_byte(8'h22, 1'b1);
    drive_byte(8'h33, 1'b1);
    drive_byte(8'h44, 1'b1);
    repeat (2 * DIV) @(negedge sys_clk);
    check("timeout_word", rx_data, 32'h4433_2211);
    check("timeout_valid", 32'(rx_valid_cnt - v0), 32'd1);
    rx_words.delete();

    // Reset in the middle of byte 2 of a looped-back word
    loop_en = 1'b1;
    send_word($urandom);
    repeat (2 * 10 * DIV + 5 * DIV) @(negedge sys_clk);
    v0 = rx_valid_cnt;
    rst_n = 1'b0;
    @(negedge sys_clk);
    check("rst_mid_txd", {31'd0, uart_txd}, 32'd1);
    check("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    word_ends.delete();
    repeat (500) @(negedge sys_clk);
    check("rst_mid_no_valid", 32'(rx_valid_cnt - v0), 32'd0);
    check("rst_mid_rx_data", rx_data, 32'd0);
    check("rst_mid_idle_txd", {31'd0, uart_txd}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
